solar_adc_spi_reader: RTL

Serial front-end that reads the panel's external 12-bit, 4-channel SPI ADC and produces the parallel `voltage`, `current` and `temperature` sample words consumed by the monitor's ADC stage. It acts as SPI master (mode 0), sweeping channels 0, 1, 2 at a programmable sample period. It presents all three results together with a one-cycle valid strobe. It sits between the board-level ADC pins and the `ai_solar_panel_monitor` sensor inputs.

---
 rtl/solar_adc_spi_reader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/solar_adc_spi_reader.sv
// solar_adc_spi_reader
//   SPI master (mode 0) for an external 12-bit, 4-channel ADC. Each sweep reads
//   channels 0, 1 and 2, then publishes all three results together with a
//   one-cycle sample_valid strobe. Back-to-back sweeps are separated by
//   SAMPLE_PERIOD idle cycles while enable stays high.
//
// Parameters
//   CLK_DIV        clk cycles per SCLK half-period (>= 1)
//   SAMPLE_PERIOD  idle clk cycles between sample_valid and the next sweep (>= 1)
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   enable           run sweeps continuously while high
//   spi_miso         ADC serial data out
//   spi_sclk         SPI clock, idles low
//   spi_cs_n         ADC chip select, active low
//   spi_mosi         command bit to the ADC
//   voltage_out      channel 0 result
//   current_out      channel 1 result
//   temperature_out  channel 2 result
//   sample_valid     one-cycle pulse when all three results update
//   busy             high from sweep start through the sample_valid cycle
module solar_adc_spi_reader #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [11:0] voltage_out,
    output logic [11:0] current_out,
    output logic [11:0] temperature_out,
    output logic        sample_valid,
    output logic        busy
);

    // One shared down-the-phase counter covers setup, half-bit, gap and wait.
    localparam int unsigned CNT_MAX = (SAMPLE_PERIOD > 2 * CLK_DIV) ? SAMPLE_PERIOD : 2 * CLK_DIV;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_GAP,
        S_UPDATE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic [1:0]    chan_q, chan_d;
    logic [15:0]   tx_q, tx_d;
    logic [11:0]   rx_q, rx_d;
    logic [11:0]   hold_q [3];
    logic [11:0]   hold_d [3];
    logic [11:0]   volt_q, volt_d;
    logic [11:0]   curr_q, curr_d;
    logic [11:0]   temp_q, temp_d;

    // Start bit, single-ended bit, channel, then twelve don't-care zeros.
    function automatic logic [15:0] cmd_frame(input logic [1:0] ch);
        return {2'b11, ch, 12'h000};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            chan_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            hold_q  <= '{default: '0};
            volt_q  <= '0;
            curr_q  <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            chan_q  <= chan_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            hold_q  <= hold_d;
            volt_q  <= volt_d;
            curr_q  <= curr_d;
            temp_q  <= temp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        chan_d  = chan_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        hold_d  = hold_q;
        volt_d  = volt_q;
        curr_d  = curr_q;
        temp_d  = temp_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = S_CS_SETUP;
                    chan_d  = 2'd0;
                    tx_d    = cmd_frame(2'd0);
                end
            end

            S_CS_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                end
            end

            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling SCLK edge: advance MOSI and sample MISO together.
                        // rx_q is only 12 bits wide, so the 4 leading null bits
                        // fall off the top by the end of the frame.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[14:0], 1'b0};
                        rx_d   = {rx_q[10:0], spi_miso};
                    end else if (bit_q == 4'd15) begin
                        state_d        = S_GAP;
                        hold_d[chan_q] = rx_q;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 4'd1;
                    end
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (chan_q == 2'd2) begin
                        // Loaded here so the new words appear in the UPDATE cycle.
                        state_d = S_UPDATE;
                        volt_d  = hold_q[0];
                        curr_d  = hold_q[1];
                        temp_d  = hold_q[2];
                    end else begin
                        state_d = S_CS_SETUP;
                        chan_d  = chan_q + 2'd1;
                        tx_d    = cmd_frame(chan_q + 2'd1);
                    end
                end
            end

            S_UPDATE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_CS_SETUP;
                        chan_d  = 2'd0;
                        tx_d    = cmd_frame(2'd0);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign spi_cs_n        = !(state_q == S_CS_SETUP || state_q == S_SHIFT);
    assign spi_sclk        = sclk_q;
    assign spi_mosi        = spi_cs_n ? 1'b0 : tx_q[15];
    assign sample_valid    = (state_q == S_UPDATE);
    assign busy            = (state_q == S_CS_SETUP) || (state_q == S_SHIFT) ||
                             (state_q == S_GAP) || (state_q == S_UPDATE);
    assign voltage_out     = volt_q;
    assign current_out     = curr_q;
    assign temperature_out = temp_q;

endmodule
